// File: rtl/kernel_pkg.sv
// Shared constants and FSM encoding for the 3x3 sliding-window generator.
package kernel_pkg;

  localparam int unsigned KERNEL_SIZE       = 3;
  localparam int unsigned DATA_SIZE_DEFAULT = 8;

  typedef enum logic {
    ST_FILL   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

endpackage

// File: rtl/line_buffer.sv
// Single-line pixel delay: o_data is the pixel accepted DEPTH enables ago.
module line_buffer #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned DEPTH     = 8
) (
  input  logic                 i_clk,
  input  logic                 i_en,
  input  logic [DATA_SIZE-1:0] i_data,
  output logic [DATA_SIZE-1:0] o_data
);

  logic [DEPTH-1:0][DATA_SIZE-1:0] mem_q;

  // Contents are frame data only; stale entries are flushed before they can form a window.
  always_ff @(posedge i_clk) begin
    if (i_en) mem_q <= {mem_q[DEPTH-2:0], i_data};
  end

  assign o_data = mem_q[DEPTH-1];

endmodule

// File: rtl/kernel_window_gen.sv
// Raster-scan 3x3 window generator: two line delays feed a shifting window
// register; windows are flagged only when fully inside the frame.
module kernel_window_gen #(
  parameter int unsigned DATA_SIZE   = kernel_pkg::DATA_SIZE_DEFAULT,
  parameter int unsigned KERNEL_SIZE = kernel_pkg::KERNEL_SIZE,
  parameter int unsigned IMG_WIDTH   = 8,
  parameter int unsigned IMG_HEIGHT  = 8
) (
  input  logic                                             i_clk,
  input  logic                                             i_nrst,
  input  logic                                             i_valid,
  input  logic                                             i_sof,
  input  logic [DATA_SIZE-1:0]                             i_data,
  output logic                                             o_valid,
  output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_SIZE-1:0] o_window,
  output logic                                             o_frame_done
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_WIN   = COL_W'(KERNEL_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_PRIME = ROW_W'(KERNEL_SIZE - 2);

  kernel_pkg::state_e state_q, state_d;

  logic [COL_W-1:0] col_q, col_eff_c;
  logic [ROW_W-1:0] row_q, row_eff_c;
  logic             col_last_c, frame_last_c;
  logic             fire_c, done_c;

  logic [DATA_SIZE-1:0] taps [KERNEL_SIZE];

  // A start-of-frame pixel is always position (0,0), whatever the counters say.
  assign col_eff_c    = i_sof ? '0 : col_q;
  assign row_eff_c    = i_sof ? '0 : row_q;
  assign col_last_c   = (col_eff_c == COL_LAST);
  assign frame_last_c = col_last_c && (row_eff_c == ROW_LAST);

  // taps[k] is the pixel k lines above the incoming one
  assign taps[0] = i_data;

  for (genvar k = 0; k < KERNEL_SIZE - 1; k++) begin : g_line
    line_buffer #(
      .DATA_SIZE (DATA_SIZE),
      .DEPTH     (IMG_WIDTH)
    ) u_line_buffer (
      .i_clk  (i_clk),
      .i_en   (i_valid),
      .i_data (taps[k]),
      .o_data (taps[k+1])
    );
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state_q <= kernel_pkg::ST_FILL;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_valid) begin
      if (i_sof) begin
        state_d = kernel_pkg::ST_FILL;
      end else begin
        unique case (state_q)
          kernel_pkg::ST_FILL:   if (col_last_c && (row_eff_c == ROW_PRIME)) state_d = kernel_pkg::ST_STREAM;
          kernel_pkg::ST_STREAM: if (frame_last_c) state_d = kernel_pkg::ST_FILL;
          default:               state_d = kernel_pkg::ST_FILL;
        endcase
      end
    end
  end

  // Columns 0..KERNEL_SIZE-2 would straddle a line wrap, so they never fire.
  always_comb begin
    fire_c = 1'b0;
    done_c = 1'b0;
    if (i_valid && !i_sof && (state_q == kernel_pkg::ST_STREAM) && (col_eff_c >= COL_WIN)) begin
      fire_c = 1'b1;
      done_c = frame_last_c;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (i_valid) begin
      col_q <= col_last_c ? '0 : col_eff_c + COL_W'(1);
      if (frame_last_c)    row_q <= '0;
      else if (col_last_c) row_q <= row_eff_c + ROW_W'(1);
      else                 row_q <= row_eff_c;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_valid      <= fire_c;
      o_frame_done <= done_c;
    end
  end

  // Shift one column in from the right; row 0 receives the oldest line.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_window <= '0;
    end else if (i_valid) begin
      for (int unsigned r = 0; r < KERNEL_SIZE; r++) begin
        for (int unsigned c = 0; c < KERNEL_SIZE - 1; c++) begin
          o_window[r][c] <= o_window[r][c+1];
        end
        o_window[r][KERNEL_SIZE-1] <= taps[KERNEL_SIZE-1-r];
      end
    end
  end

endmodule

// File: tb/tb_kernel_window_gen.sv
// Scoreboarded bench for kernel_window_gen on a 4x4 frame, pixel = row*16 + col.
module tb_kernel_window_gen;

  localparam int unsigned DW = 8;
  localparam int unsigned K  = 3;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;

  typedef logic [K-1:0][K-1:0][DW-1:0] win_t;
  typedef struct packed {
    win_t win;
    logic done;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid;
  logic          sof;
  logic [DW-1:0] data;
  logic          o_valid;
  logic          o_frame_done;
  win_t          o_window;

  exp_t          sb[$];
  exp_t          mon_e;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_valid  = 0;
  int            n_done   = 0;
  logic [DW-1:0] img [H][W];
  int            br = 0;
  int            bc = 0;

  always #5 clk = ~clk;

  kernel_window_gen #(
    .DATA_SIZE   (DW),
    .KERNEL_SIZE (K),
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H)
  ) dut (
    .i_clk        (clk),
    .i_nrst       (rst_n),
    .i_valid      (valid),
    .i_sof        (sof),
    .i_data       (data),
    .o_valid      (o_valid),
    .o_window     (o_window),
    .o_frame_done (o_frame_done)
  );

  function automatic win_t pix_win(input int r0, input int c0);
    win_t w;
    for (int i = 0; i < int'(K); i++)
      for (int j = 0; j < int'(K); j++)
        w[i][j] = 8'((r0 + i) * 16 + c0 + j);
    return w;
  endfunction

  // Drive one accepted pixel now and queue the window it should complete.
  task automatic drive(input logic [DW-1:0] d, input logic s);
    exp_t e;
    if (s) begin br = 0; bc = 0; end
    img[br][bc] = d;
    if (br >= 2 && bc >= 2) begin
      for (int i = 0; i < int'(K); i++)
        for (int j = 0; j < int'(K); j++)
          e.win[i][j] = img[br-2+i][bc-2+j];
      e.done = (br == int'(H) - 1) && (bc == int'(W) - 1);
      sb.push_back(e);
    end
    if (bc == int'(W) - 1) begin
      bc = 0;
      br = (br == int'(H) - 1) ? 0 : br + 1;
    end else begin
      bc = bc + 1;
    end
    valid = 1'b1;
    data  = d;
    sof   = s;
  endtask

  task automatic idle();
    valid = 1'b0;
    sof   = 1'b0;
  endtask

  // Scoreboard: every o_valid pops one expected window.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_frame_done) n_done++;
      if (o_valid) begin
        n_valid++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_window: o_valid=1 with window %h, required no window", o_window);
        end else begin
          mon_e = sb.pop_front();
          if (o_window !== mon_e.win || o_frame_done !== mon_e.done) begin
            n_fail++;
            $display("FAIL window_seq: got %h done=%b, required %h done=%b",
                     o_window, o_frame_done, mon_e.win, mon_e.done);
          end
        end
      end else if (o_frame_done !== 1'b0) begin
        n_checks++;
        n_fail++;
        $display("FAIL done_without_valid: o_frame_done=%b, required 0", o_frame_done);
      end
    end
  end

  task automatic check_counts(input string name, input int v0, input int d0, input int ev, input int ed);
    repeat (3) @(negedge clk);
    n_checks++;
    if ((n_valid - v0) !== ev || (n_done - d0) !== ed || sb.size() !== 0) begin
      n_fail++;
      $display("FAIL %s_counts: got valid=%0d done=%0d pending=%0d, required valid=%0d done=%0d pending=0",
               name, n_valid - v0, n_done - d0, sb.size(), ev, ed);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b0; sof = 1'b0; data = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (o_valid !== 1'b0 || o_frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pulses: got valid=%b done=%b, required 0 0", o_valid, o_frame_done);
    end
    n_checks++;
    if (o_window !== '0) begin
      n_fail++;
      $display("FAIL reset_window: got %h, required 0", o_window);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_continuous();
    int v0 = n_valid, d0 = n_done;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 11) begin
        n_checks++;
        if (o_valid !== 1'b1 || o_window !== pix_win(0, 0)) begin
          n_fail++;
          $display("FAIL first_window: got valid=%b %h, required 1 %h", o_valid, o_window, pix_win(0, 0));
        end
      end
      drive(8'((i / 4) * 16 + i % 4), 1'b0);
    end
    @(negedge clk);
    idle();
    n_checks++;
    if (o_valid !== 1'b1 || o_frame_done !== 1'b1 || o_window !== pix_win(1, 1)) begin
      n_fail++;
      $display("FAIL last_window: got valid=%b done=%b %h, required 1 1 %h",
               o_valid, o_frame_done, o_window, pix_win(1, 1));
    end
    check_counts("continuous", v0, d0, 4, 1);
  endtask

  task automatic test_gaps();
    int   v0 = n_valid, d0 = n_done;
    win_t snap = '0;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_checks++;
        if (o_window !== snap || o_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL gap_hold: got valid=%b %h, required 0 %h", o_valid, o_window, snap);
        end
      end
      if (i < 16) begin
        drive(8'((i / 4) * 16 + i % 4), 1'b0);
        @(negedge clk);
        idle();
        snap = o_window;
      end
    end
    check_counts("gaps", v0, d0, 4, 1);
  endtask

  task automatic test_border();
    int v0 = n_valid, d0 = n_done;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i > 0 && (i - 1) / 4 >= 2 && (i - 1) % 4 < 2) begin
        n_checks++;
        if (o_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL border_col%0d_row%0d: got o_valid=%b, required 0", (i - 1) % 4, (i - 1) / 4, o_valid);
        end
      end
      drive(8'((i / 4) * 16 + i % 4), 1'b0);
    end
    @(negedge clk);
    idle();
    check_counts("border", v0, d0, 4, 1);
  endtask

  task automatic test_back_to_back();
    int v0 = n_valid, d0 = n_done;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i == 27) begin
        n_checks++;
        if (o_valid !== 1'b1 || o_window !== pix_win(0, 0)) begin
          n_fail++;
          $display("FAIL b2b_second_first: got valid=%b %h, required 1 %h", o_valid, o_window, pix_win(0, 0));
        end
      end
      drive(8'(((i % 16) / 4) * 16 + i % 4), 1'b0);
    end
    @(negedge clk);
    idle();
    check_counts("back_to_back", v0, d0, 8, 2);
  endtask

  task automatic test_sof();
    int v0 = n_valid, d0 = n_done;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(8'(8'hA0 + i), i == 0);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 11) begin
        n_checks++;
        if (o_valid !== 1'b1 || o_window !== pix_win(0, 0)) begin
          n_fail++;
          $display("FAIL sof_first_window: got valid=%b %h, required 1 %h", o_valid, o_window, pix_win(0, 0));
        end
      end
      drive(8'((i / 4) * 16 + i % 4), i == 0);
    end
    @(negedge clk);
    idle();
    check_counts("sof_restart", v0, d0, 4, 1);
  endtask

  task automatic test_mid_reset();
    int v0, d0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(8'((i / 4) * 16 + i % 4), 1'b0);
    end
    @(negedge clk);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_valid !== 1'b0 || o_frame_done !== 1'b0 || o_window !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got valid=%b done=%b %h, required 0 0 0", o_valid, o_frame_done, o_window);
    end
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL mid_reset_pending: got %0d queued windows, required 0", sb.size());
    end
    sb.delete();
    br = 0;
    bc = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    v0 = n_valid;
    d0 = n_done;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(8'((i / 4) * 16 + i % 4), 1'b0);
    end
    @(negedge clk);
    idle();
    n_checks++;
    if (o_valid !== 1'b1 || o_frame_done !== 1'b1 || o_window !== pix_win(1, 1)) begin
      n_fail++;
      $display("FAIL post_reset_last: got valid=%b done=%b %h, required 1 1 %h",
               o_valid, o_frame_done, o_window, pix_win(1, 1));
    end
    check_counts("post_reset", v0, d0, 4, 1);
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gaps();
    test_border();
    test_back_to_back();
    test_sof();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "time budget exceeded");
  end

endmodule
